usart_tx_arbiter: RTL
=====================

USART_TX_ARBITER -- requirements
Module: usart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter GAP_CYCLES, default 2, idle clocks inserted between frames (0 allowed).
REQ-003 Parameter LATCH_TIMEOUT, default 16, clocks to wait for transmitter acceptance before abandoning a byte (>=2).
REQ-004 bit_clock_x1  in  1  block clock, shared with usart_tx; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester send request, held until matching ack.
REQ-007 req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i], stable while req[i] high.
REQ-008 ack  out  NUM_REQ  one-hot, one-clock pulse: requester's byte captured.
REQ-009 tx_data  out  8  byte to usart_tx data_in.
REQ-010 tx_latch  out  1  to usart_tx latch_in.
REQ-011 tx_ready  in  1  from usart_tx ready; high = byte accepted, frame in progress.
REQ-012 tx_done  in  1  from usart_tx done; high one clock at end of stop bit.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 active_id  out  $clog2(NUM_REQ)  index of requester owning current frame.
REQ-015 timeout_err  out  1  one-clock pulse when acceptance timeout fires.

Function
REQ-016 FSM states SHALL be IDLE, LATCH, WAIT_DONE, GAP.
REQ-017 IDLE: on an edge with any req bit high, SHALL select the winner round-robin, searching from last_grant+1 upward with wrap at NUM_REQ-1->0.
REQ-018 On that same edge SHALL register tx_data=req_data[winner], active_id=winner, ack[winner]=1, tx_latch=1, state->LATCH; ack SHALL clear the following clock.
REQ-019 last_grant SHALL update to winner on the grant edge; a requester holding req after ack SHALL be served again only after all other pending requesters.
REQ-020 LATCH: tx_latch SHALL stay high and tx_data stable until tx_ready sampled high; then tx_latch=0, state->WAIT_DONE on that edge.
REQ-021 LATCH: a cycle counter SHALL run from 0; if it reaches LATCH_TIMEOUT-1 with tx_ready low, SHALL drop tx_latch, pulse timeout_err, and go to GAP (or IDLE if GAP_CYCLES=0).
REQ-022 tx_ready and timeout on the same edge: acceptance SHALL win; no timeout_err.
REQ-023 tx_done SHALL be ignored outside WAIT_DONE.
REQ-024 WAIT_DONE: tx_done high SHALL move to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-025 GAP: SHALL remain exactly GAP_CYCLES clocks, then IDLE; requests ignored during GAP.
REQ-026 Requests arriving in LATCH/WAIT_DONE/GAP SHALL wait; none SHALL be lost or double-acked.
REQ-027 Back-to-back frames with GAP_CYCLES=0: IDLE SHALL last at least one clock between frames.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, ack=0, tx_latch=0, tx_data=0, busy=0, active_id=0, timeout_err=0, counters=0, last_grant=NUM_REQ-1 (first search starts at 0).
REQ-029 Reset mid-frame SHALL drop tx_latch immediately; no ack issued for the abandoned byte; after release the block SHALL restart in IDLE.

Structure
REQ-030 State encoding and default parameter constants SHALL live in a shared package usart_pkg.
REQ-031 Round-robin selection SHALL be a separate sub-module rr_select (inputs req, last_grant; outputs valid, winner); the FSM and counters stay in usart_tx_arbiter.

Verification
REQ-032 req=4'b0001, data0=8'hAA, tx_ready 2 clocks after latch, tx_done 20 clocks later -> ack[0] one pulse, tx_data=8'hAA, tx_latch high exactly 2 clocks, busy low GAP_CYCLES+1 clocks after done.
REQ-033 req=4'b1111 held, data 8'h10..8'h13 -> grant order 0,1,2,3,0; each ack single-pulse; active_id tracks.
REQ-034 tx_ready never asserted, LATCH_TIMEOUT=16 -> tx_latch high 16 clocks, one timeout_err pulse, next requester served after gap.
REQ-035 tx_ready on the timeout edge -> WAIT_DONE entered, timeout_err stays 0.
REQ-036 reset_n pulsed low during WAIT_DONE -> all outputs 0 asynchronously; after release req=4'b0100 granted first search from index 0 -> ack[2].
REQ-037 tx_done pulsed during LATCH -> ignored; state remains LATCH until tx_ready.

Source files
------------

// File: rtl/usart_pkg.sv
// usart_pkg: arbiter state encoding and default parameter values
package usart_pkg;
    typedef enum logic [1:0] {IDLE, LATCH, WAIT_DONE, GAP} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_LATCH_TIMEOUT = 16;
endpackage

// File: rtl/usart_tx_arbiter_if.sv
// usart_tx_arbiter_if: requester handshake plus usart_tx control bundle
interface usart_tx_arbiter_if
    import usart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0] ack;
    logic [7:0] tx_data;
    logic tx_latch;
    logic tx_ready;
    logic tx_done;
    logic busy;
    logic [IW-1:0] active_id;
    logic timeout_err;
    modport master (
        input req, req_data, tx_ready, tx_done,
        output ack, tx_data, tx_latch, busy, active_id, timeout_err
    );
    modport slave (
        output req, req_data, tx_ready, tx_done,
        input ack, tx_data, tx_latch, busy, active_id, timeout_err
    );
endinterface

// File: rtl/usart_tx_arbiter_rr_select.sv
// rr_select: round-robin winner search starting just after last_grant
module rr_select
    import usart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               valid,
    output logic [IW-1:0]      winner
);
    logic [IW-1:0] idx;
    assign valid = |req;
    // walk farthest-first so the nearest pending requester is the last write
    always_comb begin
        winner = '0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IW'((int'(last_grant) + i) % NUM_REQ);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: round-robin feeder of requester bytes into a single usart_tx
module usart_tx_arbiter
    import usart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int LATCH_TIMEOUT = DEF_LATCH_TIMEOUT
) (
    input logic bit_clock_x1,
    input logic reset_n,
    usart_tx_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2((LATCH_TIMEOUT > GAP_CYCLES ? LATCH_TIMEOUT : GAP_CYCLES) + 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] last_grant, last_grant_n, active_id_n, winner;
    logic [NUM_REQ-1:0] ack_n;
    logic [7:0] tx_data_n;
    logic tx_latch_n, timeout_err_n, valid;

    rr_select #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req(bus.req),
        .last_grant(last_grant),
        .valid(valid),
        .winner(winner)
    );

    assign bus.busy = state != IDLE;

    always_ff @(posedge bit_clock_x1 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            bus.ack <= '0;
            bus.tx_data <= '0;
            bus.tx_latch <= 1'b0;
            bus.active_id <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            last_grant <= last_grant_n;
            bus.ack <= ack_n;
            bus.tx_data <= tx_data_n;
            bus.tx_latch <= tx_latch_n;
            bus.active_id <= active_id_n;
            bus.timeout_err <= timeout_err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        last_grant_n = last_grant;
        ack_n = '0;
        tx_data_n = bus.tx_data;
        tx_latch_n = bus.tx_latch;
        active_id_n = bus.active_id;
        timeout_err_n = 1'b0;
        case (state)
            IDLE: if (valid) begin
                state_n = LATCH;
                cnt_n = '0;
                last_grant_n = winner;
                ack_n = NUM_REQ'(1) << winner;
                tx_data_n = bus.req_data[{winner, 3'b000} +: 8];
                tx_latch_n = 1'b1;
                active_id_n = winner;
            end
            // acceptance is checked first so it wins over a coincident timeout
            LATCH: if (bus.tx_ready) begin
                state_n = WAIT_DONE;
                tx_latch_n = 1'b0;
            end else if (cnt == LAT_LAST) begin
                state_n = AFTER_FRAME;
                cnt_n = '0;
                tx_latch_n = 1'b0;
                timeout_err_n = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            WAIT_DONE: if (bus.tx_done) begin
                state_n = AFTER_FRAME;
                cnt_n = '0;
            end
            GAP: if (cnt == GAP_LAST) begin
                state_n = IDLE;
                cnt_n = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
